trap_controller: RTL and testbench
==================================

# trap_controller

Parametrised machine-mode trap controller for the RISC-V core. It prioritises synchronous exceptions and masked, level-sensitive interrupts (timer, external, and NUM_IRQ platform lines), and owns the trap CSRs (mstatus.MIE/MPIE, mie, mip, mtvec, mepc, mcause, mtval). It sequences trap entry and MRET through a flush/redirect handshake with fetch. It sits beside the pipeline's CSR unit, between the writeback-stage exception collector and the fetch PC mux.

## Interface
- XLEN, 64, data/PC width
- NUM_IRQ, 4, platform interrupt lines, cause codes 16..16+NUM_IRQ-1 (NUM_IRQ ≤ 16)
- TVEC_RESET, 0, mtvec reset value
- CLK  in  1  core clock, all state on rising edge
- RESET  in  1  asynchronous, active-high; clears all state immediately
- EXC_VALID  in  1  synchronous exception from the oldest instruction
- EXC_CODE  in  4  exception cause code (0–15)
- EXC_PC  in  XLEN  PC of the faulting instruction
- EXC_TVAL  in  XLEN  faulting address or instruction bits
- IRQ_MTI, IRQ_MEI  in  1 each  timer and external interrupt levels
- IRQ_PLAT  in  NUM_IRQ  platform interrupt levels
- INT_PC  in  XLEN  next-to-retire PC, saved as mepc on interrupt
- MRET  in  1  MRET retiring this cycle
- CSR_WE  in  1  CSR write strobe
- CSR_ADDR  in  12  CSR address
- CSR_WDATA  in  XLEN  CSR write data
- CSR_RDATA  out  XLEN  combinational read of CSR_ADDR; 0 for unowned addresses
- FLUSH  out  1  one-cycle pipeline flush pulse
- REDIRECT_VALID  out  1  REDIRECT_PC is valid
- REDIRECT_PC  out  XLEN  fetch target
- REDIRECT_READY  in  1  fetch accepts the redirect
- BUSY  out  1  high in any state other than IDLE

## Operation
- CSRs owned by the block:
  - mstatus 0x300: bit 3 MIE, bit 7 MPIE, MPP bits 12:11 read as 2'b11.
  - mie 0x304.
  - mtvec 0x305: bits [1:0] MODE, 0 = direct, 1 = vectored.
  - mepc 0x341: bits [1:0] forced to 0.
  - mcause 0x342; mtval 0x343.
  - mip 0x344: read-only, reflects the live interrupt inputs.
- mip/mie bit map: MTI → bit 7, MEI → bit 11, IRQ_PLAT[i] → bit 16+i. Writes to unimplemented bits are dropped.
- An interrupt is pending when mip & mie is nonzero and mstatus.MIE = 1.
- Priority, highest first: EXC_VALID, MEI, MTI, IRQ_PLAT[0] … IRQ_PLAT[NUM_IRQ-1].
- mcause value:
  - exception: {1'b0, zero-extended EXC_CODE}
  - interrupt: {1'b1, zeros, code}
- Trap target:
  - direct mode: {mtvec[XLEN-1:2], 2'b00}
  - vectored mode, interrupts: that base + 4×code (XLEN wrap-around)
  - vectored mode, exceptions: the base
- FSM states IDLE, TRAP_RDR, RET_RDR.
  - IDLE → TRAP_RDR on an exception or pending interrupt. At that same edge the block writes:
    - mepc ← EXC_PC (exception) or INT_PC (interrupt)
    - mcause ← cause value
    - mtval ← EXC_TVAL (exception) or 0 (interrupt)
    - MPIE ← MIE, MIE ← 0
    - FLUSH ← 1, REDIRECT_PC ← target
  - IDLE → RET_RDR on MRET with no trap. At that edge: MIE ← MPIE, MPIE ← 1, REDIRECT_PC ← mepc, FLUSH ← 1.
  - TRAP_RDR or RET_RDR → IDLE on the edge where REDIRECT_VALID && REDIRECT_READY.
- While BUSY, EXC_VALID and MRET are ignored. Interrupts remain pending by level only; nothing is latched.
- Same-cycle conflicts:
  - A trap beats MRET; the MRET is dropped.
  - A trap beats a CSR write to mstatus/mepc/mcause/mtval in the same cycle.
  - CSR writes to mie/mtvec always apply.
  - CSR writes in non-IDLE states apply normally.
- RESET mid-redirect: the state returns to IDLE and REDIRECT_VALID drops immediately. No partial CSR update survives.

## Timing
- Reset values: state IDLE; FLUSH 0; REDIRECT_VALID 0; REDIRECT_PC 0; BUSY 0; mtvec = TVEC_RESET; all other CSRs 0.
- Event sampled at edge N:
  - FLUSH is high during cycle N+1 only.
  - REDIRECT_VALID is high from N+1 until the handshake edge.
  - The CSR updates are visible on CSR_RDATA from N+1.
- REDIRECT_PC and REDIRECT_VALID are registered and stable while waiting for READY.
- Minimum turnaround is 1 cycle in the redirect state: READY held high returns the FSM to IDLE at edge N+1. A new trap can then be sampled at edge N+2.
- After MRET, an interrupt re-enabled by MPIE is taken no earlier than the first IDLE edge after the return handshake.

## Test plan
- Illegal instruction: reset, mtvec = 0x1000, EXC_VALID with code 2, EXC_PC 0x80, EXC_TVAL 0xDEAD, READY = 1. Expect FLUSH pulse, REDIRECT_PC 0x1000, mepc 0x80, mcause 2, mtval 0xDEAD, MIE 0, MPIE = old MIE.
- Vectored timer interrupt: mtvec = 0x2001, mie bit 7 = 1, MIE = 1, IRQ_MTI = 1, INT_PC 0x44. Expect REDIRECT_PC 0x201C, mcause {1,…,7}, mepc 0x44.
- Priority: EXC_VALID (code 4), IRQ_MEI and IRQ_PLAT[0] all asserted in the same cycle. Expect mcause 4. After MRET, the MEI trap is taken with mcause {1,…,11}.
- Handshake stall: hold READY = 0 for 5 cycles with a new EXC_VALID during the stall. Expect REDIRECT_VALID and REDIRECT_PC stable, the second exception ignored, and exactly one FLUSH pulse.
- MRET restore: with MPIE = 1 and mepc = 0x300, MRET redirects to 0x300 and sets MIE = 1. A masked-pending IRQ_PLAT[2] with mie bit 18 = 1 then traps with mcause 18.
- Async reset: assert RESET while in TRAP_RDR. Expect REDIRECT_VALID 0 before the next edge, CSRs at their reset values, and mtvec = TVEC_RESET.

Source files
------------

// File: rtl/trap_controller.sv
// Machine-mode trap controller: prioritises exceptions and masked interrupts,
// owns the trap CSRs and sequences trap entry / MRET through a redirect handshake.
module trap_controller #(
    parameter int              XLEN       = 64,
    parameter int              NUM_IRQ    = 4,
    parameter logic [XLEN-1:0] TVEC_RESET = {XLEN{1'b0}}
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_exc_valid,
    input  logic [3:0]         i_exc_code,
    input  logic [XLEN-1:0]    i_exc_pc,
    input  logic [XLEN-1:0]    i_exc_tval,
    input  logic               i_irq_mti,
    input  logic               i_irq_mei,
    input  logic [NUM_IRQ-1:0] i_irq_plat,
    input  logic [XLEN-1:0]    i_int_pc,
    input  logic               i_mret,
    input  logic               i_csr_we,
    input  logic [11:0]        i_csr_addr,
    input  logic [XLEN-1:0]    i_csr_wdata,
    output logic [XLEN-1:0]    o_csr_rdata,
    output logic               o_flush,
    output logic               o_redirect_valid,
    output logic [XLEN-1:0]    o_redirect_pc,
    input  logic               i_redirect_ready,
    output logic               o_busy
);

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    localparam logic [XLEN-1:0] PC_ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        TRAP_RDR = 2'd1,
        RET_RDR  = 2'd2
    } state_t;

    // Places the interrupt sources on their mip/mie bit positions.
    function automatic logic [XLEN-1:0] f_irq_map(input logic mti, input logic mei,
                                                   input logic [NUM_IRQ-1:0] plat);
        logic [XLEN-1:0] v;
        v     = {XLEN{1'b0}};
        v[7]  = mti;
        v[11] = mei;
        for (int i = 0; i < NUM_IRQ; i++) begin
            v[16+i] = plat[i];
        end
        return v;
    endfunction

    localparam logic [XLEN-1:0] MIE_MASK = f_irq_map(1'b1, 1'b1, {NUM_IRQ{1'b1}});

    state_t          r_state;
    logic            r_mstatus_mie;
    logic            r_mstatus_mpie;
    logic [XLEN-1:0] r_mie;
    logic [XLEN-1:0] r_mtvec;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mtval;
    logic            r_flush;
    logic            r_redirect_valid;
    logic [XLEN-1:0] r_redirect_pc;
    logic            r_busy;

    logic [XLEN-1:0] w_mip;
    logic [XLEN-1:0] w_irq_act;
    logic            w_irq_pend;
    logic [4:0]      w_plat_code;
    logic [4:0]      w_int_code;
    logic            w_idle;
    logic            w_take_exc;
    logic            w_take_int;
    logic            w_take_trap;
    logic            w_take_mret;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_tvec_base;
    logic [XLEN-1:0] w_trap_target;
    logic [XLEN-1:0] w_mstatus;
    logic [XLEN-1:0] w_csr_rdata;
    logic            w_wr_mstatus;
    logic            w_wr_mie;
    logic            w_wr_mtvec;
    logic            w_wr_mepc;
    logic            w_wr_mcause;
    logic            w_wr_mtval;

    assign w_mip      = f_irq_map(i_irq_mti, i_irq_mei, i_irq_plat);
    assign w_irq_act  = w_mip & r_mie;
    assign w_irq_pend = r_mstatus_mie && (|w_irq_act);

    // Lowest-numbered enabled platform line wins among the platform sources.
    always_comb begin
        w_plat_code = 5'd16;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            w_plat_code = w_irq_act[16+i] ? 5'(16 + i) : w_plat_code;
        end
    end

    // Fixed interrupt priority: MEI, then MTI, then platform lines.
    always_comb begin
        w_int_code = 5'd0;
        if (w_irq_act[11]) begin
            w_int_code = 5'd11;
        end else if (w_irq_act[7]) begin
            w_int_code = 5'd7;
        end else begin
            w_int_code = w_plat_code;
        end
    end

    assign w_idle      = (r_state == IDLE);
    assign w_take_exc  = w_idle && i_exc_valid;
    assign w_take_int  = w_idle && !i_exc_valid && w_irq_pend;
    assign w_take_trap = w_take_exc || w_take_int;
    assign w_take_mret = w_idle && i_mret && !w_take_trap;

    assign w_cause = w_take_exc ? {{(XLEN-4){1'b0}}, i_exc_code}
                                : {1'b1, {(XLEN-6){1'b0}}, w_int_code};

    assign w_tvec_base   = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_trap_target = (w_take_int && r_mtvec[0])
                         ? w_tvec_base + {{(XLEN-7){1'b0}}, w_int_code, 2'b00}
                         : w_tvec_base;

    // A trap entering this cycle owns the registers it saves into.
    assign w_wr_mstatus = i_csr_we && (i_csr_addr == CSR_MSTATUS) && !w_take_trap;
    assign w_wr_mepc    = i_csr_we && (i_csr_addr == CSR_MEPC)    && !w_take_trap;
    assign w_wr_mcause  = i_csr_we && (i_csr_addr == CSR_MCAUSE)  && !w_take_trap;
    assign w_wr_mtval   = i_csr_we && (i_csr_addr == CSR_MTVAL)   && !w_take_trap;
    assign w_wr_mie     = i_csr_we && (i_csr_addr == CSR_MIE);
    assign w_wr_mtvec   = i_csr_we && (i_csr_addr == CSR_MTVEC);

    assign w_mstatus = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, r_mstatus_mpie,
                        3'b000, r_mstatus_mie, 3'b000};

    // CSR read mux; unowned addresses read as zero.
    always_comb begin
        w_csr_rdata = {XLEN{1'b0}};
        case (i_csr_addr)
            CSR_MSTATUS: w_csr_rdata = w_mstatus;
            CSR_MIE:     w_csr_rdata = r_mie;
            CSR_MTVEC:   w_csr_rdata = r_mtvec;
            CSR_MEPC:    w_csr_rdata = r_mepc;
            CSR_MCAUSE:  w_csr_rdata = r_mcause;
            CSR_MTVAL:   w_csr_rdata = r_mtval;
            CSR_MIP:     w_csr_rdata = w_mip;
            default:     w_csr_rdata = {XLEN{1'b0}};
        endcase
    end

    // Trap FSM, CSR state and registered redirect outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state          <= IDLE;
            r_mstatus_mie    <= 1'b0;
            r_mstatus_mpie   <= 1'b0;
            r_mie            <= {XLEN{1'b0}};
            r_mtvec          <= TVEC_RESET;
            r_mepc           <= {XLEN{1'b0}};
            r_mcause         <= {XLEN{1'b0}};
            r_mtval          <= {XLEN{1'b0}};
            r_flush          <= 1'b0;
            r_redirect_valid <= 1'b0;
            r_redirect_pc    <= {XLEN{1'b0}};
            r_busy           <= 1'b0;
        end else begin
            r_flush <= 1'b0;
            if (w_wr_mie) begin
                r_mie <= i_csr_wdata & MIE_MASK;
            end
            if (w_wr_mtvec) begin
                r_mtvec <= {i_csr_wdata[XLEN-1:2], 1'b0, i_csr_wdata[0]};
            end
            if (w_wr_mstatus) begin
                r_mstatus_mie  <= i_csr_wdata[3];
                r_mstatus_mpie <= i_csr_wdata[7];
            end
            if (w_wr_mepc) begin
                r_mepc <= i_csr_wdata & PC_ALIGN;
            end
            if (w_wr_mcause) begin
                r_mcause <= i_csr_wdata;
            end
            if (w_wr_mtval) begin
                r_mtval <= i_csr_wdata;
            end

            case (r_state)
                IDLE: begin
                    if (w_take_trap) begin
                        r_state          <= TRAP_RDR;
                        r_mepc           <= (w_take_exc ? i_exc_pc : i_int_pc) & PC_ALIGN;
                        r_mcause         <= w_cause;
                        r_mtval          <= w_take_exc ? i_exc_tval : {XLEN{1'b0}};
                        r_mstatus_mpie   <= r_mstatus_mie;
                        r_mstatus_mie    <= 1'b0;
                        r_flush          <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= w_trap_target;
                        r_busy           <= 1'b1;
                    end else if (w_take_mret) begin
                        r_state          <= RET_RDR;
                        r_mstatus_mie    <= r_mstatus_mpie;
                        r_mstatus_mpie   <= 1'b1;
                        r_flush          <= 1'b1;
                        r_redirect_valid <= 1'b1;
                        r_redirect_pc    <= r_mepc;
                        r_busy           <= 1'b1;
                    end
                end
                TRAP_RDR, RET_RDR: begin
                    if (i_redirect_ready) begin
                        r_state          <= IDLE;
                        r_redirect_valid <= 1'b0;
                        r_busy           <= 1'b0;
                    end
                end
                default: begin
                    r_state          <= IDLE;
                    r_redirect_valid <= 1'b0;
                    r_busy           <= 1'b0;
                end
            endcase
        end
    end

    assign o_csr_rdata      = w_csr_rdata;
    assign o_flush          = r_flush;
    assign o_redirect_valid = r_redirect_valid;
    assign o_redirect_pc    = r_redirect_pc;
    assign o_busy           = r_busy;

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: table of trap-entry vectors plus
// hand sequences for stall, MRET and reset; redirects checked via a scoreboard.
module tb_trap_controller;

    localparam logic [11:0] A_MSTATUS = 12'h300;
    localparam logic [11:0] A_MIE     = 12'h304;
    localparam logic [11:0] A_MTVEC   = 12'h305;
    localparam logic [11:0] A_MEPC    = 12'h341;
    localparam logic [11:0] A_MCAUSE  = 12'h342;
    localparam logic [11:0] A_MTVAL   = 12'h343;
    localparam logic [11:0] A_MIP     = 12'h344;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exc_valid, irq_mti, irq_mei, mret, csr_we, ready;
    logic [3:0]  exc_code, irq_plat;
    logic [63:0] exc_pc, exc_tval, int_pc, csr_wdata;
    logic [11:0] csr_addr;
    logic [63:0] csr_rdata, rpc;
    logic        flush, rvalid, busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        string       name;
        logic [63:0] mtvec, mie, mstatus;
        logic        exc_valid;
        logic [3:0]  exc_code;
        logic [63:0] exc_pc, exc_tval;
        logic        mti, mei;
        logic [3:0]  plat;
        logic [63:0] int_pc;
        logic [63:0] exp_pc, exp_cause, exp_mepc, exp_mtval, exp_mstatus;
    } vec_t;

    vec_t vecs[7];

    trap_controller #(.XLEN(64), .NUM_IRQ(4), .TVEC_RESET(64'h0)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_exc_valid(exc_valid), .i_exc_code(exc_code), .i_exc_pc(exc_pc), .i_exc_tval(exc_tval),
        .i_irq_mti(irq_mti), .i_irq_mei(irq_mei), .i_irq_plat(irq_plat), .i_int_pc(int_pc),
        .i_mret(mret), .i_csr_we(csr_we), .i_csr_addr(csr_addr), .i_csr_wdata(csr_wdata),
        .o_csr_rdata(csr_rdata), .o_flush(flush), .o_redirect_valid(rvalid),
        .o_redirect_pc(rpc), .i_redirect_ready(ready), .o_busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, got, exp);
        end
    endtask

    // Advance one edge, then score any flush pulse against the queued redirect.
    task automatic tick();
        logic [63:0] e;
        @(posedge clk);
        #1;
        if (flush === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_flush: got flush with pc %h, required no flush", rpc);
            end else begin
                e = exp_q.pop_front();
                if (rpc !== e || rvalid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL redirect: got pc %h valid %b, required pc %h valid 1", rpc, rvalid, e);
                end
            end
        end
    endtask

    task automatic clear_inputs();
        exc_valid = 1'b0; exc_code = 4'd0; exc_pc = 64'h0; exc_tval = 64'h0;
        irq_mti = 1'b0; irq_mei = 1'b0; irq_plat = 4'h0; int_pc = 64'h0;
        mret = 1'b0; csr_we = 1'b0; csr_addr = 12'h000; csr_wdata = 64'h0; ready = 1'b1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [63:0] d);
        csr_we = 1'b1; csr_addr = a; csr_wdata = d;
        tick();
        csr_we = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [11:0] a, input logic [63:0] e);
        csr_addr = a;
        #1;
        chk(name, csr_rdata, e);
    endtask

    initial begin
        vecs[0] = '{"illegal", 64'h1000, 64'h0, 64'h8, 1'b1, 4'd2, 64'h80, 64'hDEAD, 1'b0, 1'b0, 4'h0, 64'h0,
                    64'h1000, 64'h2, 64'h80, 64'hDEAD, 64'h1880};
        vecs[1] = '{"vec_timer", 64'h2001, 64'h80, 64'h8, 1'b0, 4'd0, 64'h0, 64'h0, 1'b1, 1'b0, 4'h0, 64'h44,
                    64'h201C, 64'h8000_0000_0000_0007, 64'h44, 64'h0, 64'h1880};
        vecs[2] = '{"exc_over_irq", 64'h1000, 64'h10800, 64'h8, 1'b1, 4'd4, 64'h100, 64'h55, 1'b0, 1'b1, 4'h1, 64'h900,
                    64'h1000, 64'h4, 64'h100, 64'h55, 64'h1880};
        vecs[3] = '{"vec_exc_base", 64'h3001, 64'h0, 64'h0, 1'b1, 4'd5, 64'h204, 64'h7, 1'b0, 1'b0, 4'h0, 64'h0,
                    64'h3000, 64'h5, 64'h204, 64'h7, 64'h1800};
        vecs[4] = '{"mei_first", 64'h2001, 64'hF0880, 64'h8, 1'b0, 4'd0, 64'h0, 64'h0, 1'b1, 1'b1, 4'hF, 64'h48,
                    64'h202C, 64'h8000_0000_0000_000B, 64'h48, 64'h0, 64'h1880};
        vecs[5] = '{"plat_lowest", 64'h2001, 64'hA0000, 64'h8, 1'b0, 4'd0, 64'h0, 64'h0, 1'b1, 1'b0, 4'hA, 64'h203,
                    64'h2044, 64'h8000_0000_0000_0011, 64'h200, 64'h0, 64'h1880};
        vecs[6] = '{"vec_wrap", 64'hFFFF_FFFF_FFFF_FFF1, 64'h800, 64'h8, 1'b0, 4'd0, 64'h0, 64'h0, 1'b0, 1'b1, 4'h0, 64'h10,
                    64'h1C, 64'h8000_0000_0000_000B, 64'h10, 64'h0, 64'h1880};

        // Reset state and basic CSR behaviour.
        do_reset();
        chk("rst_flush", {63'd0, flush}, 64'd0);
        chk("rst_valid", {63'd0, rvalid}, 64'd0);
        chk("rst_pc", rpc, 64'h0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        rd_chk("rst_mtvec", A_MTVEC, 64'h0);
        rd_chk("rst_mstatus", A_MSTATUS, 64'h1800);
        rd_chk("rst_mcause", A_MCAUSE, 64'h0);
        rd_chk("unowned_csr", 12'h340, 64'h0);
        csr_wr(A_MIE, 64'hFFFF_FFFF_FFFF_FFFF);
        rd_chk("mie_mask", A_MIE, 64'hF0880);
        irq_plat = 4'b0101; irq_mti = 1'b1;
        rd_chk("mip_live", A_MIP, 64'h50080);
        clear_inputs();

        // Table of single-trap vectors.
        for (int k = 0; k < 7; k++) begin
            do_reset();
            csr_wr(A_MTVEC, vecs[k].mtvec);
            csr_wr(A_MIE, vecs[k].mie);
            csr_wr(A_MSTATUS, vecs[k].mstatus);
            exc_valid = vecs[k].exc_valid; exc_code = vecs[k].exc_code;
            exc_pc = vecs[k].exc_pc; exc_tval = vecs[k].exc_tval;
            irq_mti = vecs[k].mti; irq_mei = vecs[k].mei; irq_plat = vecs[k].plat;
            int_pc = vecs[k].int_pc;
            exp_q.push_back(vecs[k].exp_pc);
            tick();
            chk({vecs[k].name, ".busy"}, {63'd0, busy}, 64'd1);
            clear_inputs();
            tick();
            chk({vecs[k].name, ".idle"}, {62'd0, busy, rvalid}, 64'd0);
            rd_chk({vecs[k].name, ".mepc"}, A_MEPC, vecs[k].exp_mepc);
            rd_chk({vecs[k].name, ".mcause"}, A_MCAUSE, vecs[k].exp_cause);
            rd_chk({vecs[k].name, ".mtval"}, A_MTVAL, vecs[k].exp_mtval);
            rd_chk({vecs[k].name, ".mstatus"}, A_MSTATUS, vecs[k].exp_mstatus);
        end

        // Handshake stall with a second exception ignored while busy.
        do_reset();
        csr_wr(A_MTVEC, 64'h1000);
        ready = 1'b0;
        exc_valid = 1'b1; exc_code = 4'd2; exc_pc = 64'h80; exc_tval = 64'h1;
        exp_q.push_back(64'h1000);
        tick();
        exc_valid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            if (s == 1) begin
                exc_valid = 1'b1; exc_code = 4'd7; exc_pc = 64'h500;
            end
            tick();
            exc_valid = 1'b0;
            chk("stall_valid", {63'd0, rvalid}, 64'd1);
            chk("stall_pc", rpc, 64'h1000);
        end
        ready = 1'b1;
        tick();
        chk("stall_release", {63'd0, rvalid}, 64'd0);
        rd_chk("stall_mcause", A_MCAUSE, 64'h2);
        rd_chk("stall_mepc", A_MEPC, 64'h80);

        // Exception beats MEI; MEI taken only after the MRET handshake.
        do_reset();
        csr_wr(A_MTVEC, 64'h1000);
        csr_wr(A_MIE, 64'h800);
        csr_wr(A_MSTATUS, 64'h8);
        exc_valid = 1'b1; exc_code = 4'd4; exc_pc = 64'h100; irq_mei = 1'b1; int_pc = 64'h900;
        exp_q.push_back(64'h1000);
        tick();
        exc_valid = 1'b0;
        tick();
        rd_chk("prio_mcause", A_MCAUSE, 64'h4);
        tick();
        chk("prio_masked_idle", {63'd0, busy}, 64'd0);
        mret = 1'b1;
        exp_q.push_back(64'h100);
        exp_q.push_back(64'h1000);
        tick();
        mret = 1'b0;
        chk("mret_busy", {63'd0, busy}, 64'd1);
        tick();
        chk("mret_return_idle", {63'd0, busy}, 64'd0);
        tick();
        chk("mei_taken", {63'd0, busy}, 64'd1);
        irq_mei = 1'b0;
        tick();
        rd_chk("mei_mcause", A_MCAUSE, 64'h8000_0000_0000_000B);
        rd_chk("mei_mepc", A_MEPC, 64'h900);
        rd_chk("mei_mstatus", A_MSTATUS, 64'h1880);

        // MRET restore then a platform interrupt previously masked by MIE.
        do_reset();
        csr_wr(A_MEPC, 64'h302);
        rd_chk("mepc_align", A_MEPC, 64'h300);
        csr_wr(A_MSTATUS, 64'h80);
        csr_wr(A_MIE, 64'h40000);
        irq_plat = 4'b0100; int_pc = 64'h500;
        tick();
        tick();
        chk("masked_no_trap", {63'd0, busy}, 64'd0);
        mret = 1'b1;
        exp_q.push_back(64'h300);
        exp_q.push_back(64'h0);
        tick();
        mret = 1'b0;
        rd_chk("mret_mstatus", A_MSTATUS, 64'h1888);
        tick();
        tick();
        irq_plat = 4'h0;
        tick();
        rd_chk("plat2_mcause", A_MCAUSE, 64'h8000_0000_0000_0012);
        rd_chk("plat2_mepc", A_MEPC, 64'h500);

        // Asynchronous reset while waiting in TRAP_RDR.
        do_reset();
        csr_wr(A_MTVEC, 64'h4000);
        ready = 1'b0;
        exc_valid = 1'b1; exc_code = 4'd1; exc_pc = 64'h10; exc_tval = 64'h99;
        exp_q.push_back(64'h4000);
        tick();
        exc_valid = 1'b0;
        chk("arst_pre_valid", {63'd0, rvalid}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", {63'd0, rvalid}, 64'd0);
        chk("arst_busy_flush", {62'd0, busy, flush}, 64'd0);
        rd_chk("arst_mtvec", A_MTVEC, 64'h0);
        rd_chk("arst_mepc", A_MEPC, 64'h0);
        rd_chk("arst_mcause", A_MCAUSE, 64'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready = 1'b1;
        tick();
        tick();
        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
